// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Client side of the hazard unit handshake. Owns the IF/ID and
//                ID/EX control latches. Feeds register selects, load flag and
//                EX PC source to the hazard unit. Applies PC enable, stall and
//                flush responses. Keeps saturating stall/flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             mem_wait,
    input  logic [31:0]      imemload,
    input  logic [4:0]       id_wsel,
    input  logic             id_dren,
    input  logic [1:0]       id_pc_src,
    input  logic             id_is_branch,
    input  logic             ex_br_taken,
    input  logic             hu_flushed,
    input  logic             hu_pc_en,
    input  logic             hu_id_en,
    output logic [1:0]       hu_pc_src,
    output logic             hu_d_ren,
    output logic [4:0]       hu_rsel1,
    output logic [4:0]       hu_rsel2,
    output logic [4:0]       hu_wsel,
    output logic             pc_wen,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline latches
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic             r_idex_valid;
    logic [4:0]       r_idex_wsel;
    logic             r_idex_dren;
    logic [1:0]       r_idex_pc_src;
    logic             r_idex_is_branch;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Edge qualifiers: the whole front end freezes unless fetch returned and
    // MEM is not waiting. Flush outranks stall.
    logic w_adv;
    logic w_flush;
    logic w_stall;

    assign w_adv   = ihit & ~mem_wait;
    assign w_flush = w_adv & hu_flushed;
    assign w_stall = w_adv & ~hu_flushed & ~hu_id_en;

    // IF/ID latch: NOP on flush, hold on stall or freeze, else capture fetch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (w_flush) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (w_adv && hu_id_en) begin
            r_ifid_instr <= imemload;
            r_ifid_valid <= 1'b1;
        end
    end

    // ID/EX latch: bubble on flush or stall, else take decoded fields
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_idex_valid     <= 1'b0;
            r_idex_wsel      <= 5'd0;
            r_idex_dren      <= 1'b0;
            r_idex_pc_src    <= 2'd0;
            r_idex_is_branch <= 1'b0;
        end else if (w_flush || w_stall) begin
            r_idex_valid     <= 1'b0;
            r_idex_wsel      <= 5'd0;
            r_idex_dren      <= 1'b0;
            r_idex_pc_src    <= 2'd0;
            r_idex_is_branch <= 1'b0;
        end else if (w_adv) begin
            r_idex_valid     <= r_ifid_valid;
            r_idex_wsel      <= id_wsel;
            r_idex_dren      <= id_dren;
            r_idex_pc_src    <= id_pc_src;
            r_idex_is_branch <= id_is_branch;
        end
    end

    // Saturating event counters; a simultaneous flush+stall counts as flush
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    // Hazard-unit request signals, masked by latch validity
    always_comb begin
        hu_rsel1  = r_ifid_valid ? r_ifid_instr[25:21] : 5'd0;
        hu_rsel2  = r_ifid_valid ? r_ifid_instr[20:16] : 5'd0;
        hu_wsel   = r_idex_valid ? r_idex_wsel : 5'd0;
        hu_d_ren  = r_idex_valid & r_idex_dren;
        hu_pc_src = r_idex_pc_src;
        if (!r_idex_valid || (r_idex_is_branch && !ex_br_taken)) begin
            hu_pc_src = 2'd0;
        end
    end

    assign pc_wen     = w_adv & hu_pc_en;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;
    assign idex_valid = r_idex_valid;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int C_CNT_W = 16;

    logic               CLK;
    logic               nRST;
    logic               ihit;
    logic               mem_wait;
    logic [31:0]        imemload;
    logic [4:0]         id_wsel;
    logic               id_dren;
    logic [1:0]         id_pc_src;
    logic               id_is_branch;
    logic               ex_br_taken;
    logic               hu_flushed;
    logic               hu_pc_en;
    logic               hu_id_en;
    logic [1:0]         hu_pc_src;
    logic               hu_d_ren;
    logic [4:0]         hu_rsel1;
    logic [4:0]         hu_rsel2;
    logic [4:0]         hu_wsel;
    logic               pc_wen;
    logic [31:0]        ifid_instr;
    logic               ifid_valid;
    logic               idex_valid;
    logic [C_CNT_W-1:0] stall_cnt;
    logic [C_CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(
        .CNT_W     (C_CNT_W),
        .NOP_INSTR (32'h00000000)
    ) u_dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .mem_wait     (mem_wait),
        .imemload     (imemload),
        .id_wsel      (id_wsel),
        .id_dren      (id_dren),
        .id_pc_src    (id_pc_src),
        .id_is_branch (id_is_branch),
        .ex_br_taken  (ex_br_taken),
        .hu_flushed   (hu_flushed),
        .hu_pc_en     (hu_pc_en),
        .hu_id_en     (hu_id_en),
        .hu_pc_src    (hu_pc_src),
        .hu_d_ren     (hu_d_ren),
        .hu_rsel1     (hu_rsel1),
        .hu_rsel2     (hu_rsel2),
        .hu_wsel      (hu_wsel),
        .pc_wen       (pc_wen),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .idex_valid   (idex_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // 10-unit clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 unit after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; mem_wait = 1'b0; imemload = 32'd0;
        id_wsel = 5'd0; id_dren = 1'b0; id_pc_src = 2'd0; id_is_branch = 1'b0;
        ex_br_taken = 1'b0; hu_flushed = 1'b0; hu_pc_en = 1'b0; hu_id_en = 1'b0;
        #12;
        // Reset state
        check_val("rst_instr", ifid_instr, 32'h00000000);
        check_val("rst_ifv", 32'(ifid_valid), 32'd0);
        check_val("rst_idv", 32'(idex_valid), 32'd0);
        check_val("rst_stall", 32'(stall_cnt), 32'd0);
        check_val("rst_flush", 32'(flush_cnt), 32'd0);
        check_val("rst_pcsrc", 32'(hu_pc_src), 32'd0);
        nRST = 1'b1;

        // 1: first fetch
        ihit = 1'b1; hu_id_en = 1'b1; hu_pc_en = 1'b1; imemload = 32'h8C220004;
        #1;
        check_val("t1_pcwen", 32'(pc_wen), 32'd1);
        step();
        check_val("t1_ifv", 32'(ifid_valid), 32'd1);
        check_val("t1_instr", ifid_instr, 32'h8C220004);
        check_val("t1_rsel1", 32'(hu_rsel1), 32'd1);
        check_val("t1_rsel2", 32'(hu_rsel2), 32'd2);
        check_val("t1_stall", 32'(stall_cnt), 32'd0);
        check_val("t1_idv", 32'(idex_valid), 32'd0);

        // 2: load advances into EX, then a stall
        id_wsel = 5'd2; id_dren = 1'b1; imemload = 32'h00430820;
        step();
        check_val("t2_idv", 32'(idex_valid), 32'd1);
        check_val("t2_wsel", 32'(hu_wsel), 32'd2);
        check_val("t2_dren", 32'(hu_d_ren), 32'd1);
        check_val("t2_instr", ifid_instr, 32'h00430820);
        hu_id_en = 1'b0; imemload = 32'hDEADBEEF;
        step();
        check_val("t2_hold", ifid_instr, 32'h00430820);
        check_val("t2_bub", 32'(idex_valid), 32'd0);
        check_val("t2_bubw", 32'(hu_wsel), 32'd0);
        check_val("t2_stall", 32'(stall_cnt), 32'd1);

        // 3: branch in EX, then flush
        hu_id_en = 1'b1; id_wsel = 5'd0; id_dren = 1'b0;
        id_pc_src = 2'd1; id_is_branch = 1'b1; imemload = 32'h10220003;
        step();
        check_val("t3_idv", 32'(idex_valid), 32'd1);
        check_val("t3_nt", 32'(hu_pc_src), 32'd0);
        ex_br_taken = 1'b1;
        #1;
        check_val("t3_tk", 32'(hu_pc_src), 32'd1);
        hu_flushed = 1'b1;
        step();
        check_val("t3_instr", ifid_instr, 32'h00000000);
        check_val("t3_ifv", 32'(ifid_valid), 32'd0);
        check_val("t3_idv0", 32'(idex_valid), 32'd0);
        check_val("t3_flush", 32'(flush_cnt), 32'd1);
        check_val("t3_stall", 32'(stall_cnt), 32'd1);
        check_val("t3_pcsrc", 32'(hu_pc_src), 32'd0);

        // Refill: jr (pc_src=2, not a branch) into EX
        hu_flushed = 1'b0; ex_br_taken = 1'b0;
        id_wsel = 5'd5; id_dren = 1'b1; id_pc_src = 2'd0; id_is_branch = 1'b0;
        imemload = 32'h8C220004;
        step();
        check_val("rf_ifv", 32'(ifid_valid), 32'd1);
        check_val("rf_idv", 32'(idex_valid), 32'd0);
        id_pc_src = 2'd2; imemload = 32'h00A53020;
        step();
        check_val("rf_instr", ifid_instr, 32'h00A53020);
        check_val("rf_wsel", 32'(hu_wsel), 32'd5);
        check_val("rf_jr", 32'(hu_pc_src), 32'd2);

        // 4: freeze with flush+stall requested
        mem_wait = 1'b1; hu_flushed = 1'b1; hu_id_en = 1'b0; imemload = 32'hFFFFFFFF;
        #1;
        check_val("t4_pcwen", 32'(pc_wen), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_val("t4_instr", ifid_instr, 32'h00A53020);
        check_val("t4_ifv", 32'(ifid_valid), 32'd1);
        check_val("t4_wsel", 32'(hu_wsel), 32'd5);
        check_val("t4_stall", 32'(stall_cnt), 32'd1);
        check_val("t4_flush", 32'(flush_cnt), 32'd1);

        // Simultaneous flush+stall counts as flush only
        mem_wait = 1'b0;
        step();
        check_val("fs_flush", 32'(flush_cnt), 32'd2);
        check_val("fs_stall", 32'(stall_cnt), 32'd1);
        check_val("fs_ifv", 32'(ifid_valid), 32'd0);

        // 5: stall counter saturation
        hu_flushed = 1'b0; hu_pc_en = 1'b0;
        #1;
        check_val("t5_pcwen", 32'(pc_wen), 32'd0);
        for (int i = 0; i < 65533; i++) @(posedge CLK);
        #1;
        check_val("t5_fffe", 32'(stall_cnt), 32'h0000FFFE);
        step();
        check_val("t5_ffff", 32'(stall_cnt), 32'h0000FFFF);
        step();
        check_val("t5_sat", 32'(stall_cnt), 32'h0000FFFF);
        check_val("t5_flush", 32'(flush_cnt), 32'd2);

        // 6: async reset mid-cycle during a stall
        #2;
        nRST = 1'b0;
        #1;
        check_val("t6_instr", ifid_instr, 32'h00000000);
        check_val("t6_ifv", 32'(ifid_valid), 32'd0);
        check_val("t6_idv", 32'(idex_valid), 32'd0);
        check_val("t6_stall", 32'(stall_cnt), 32'd0);
        check_val("t6_flush", 32'(flush_cnt), 32'd0);
        check_val("t6_rsel1", 32'(hu_rsel1), 32'd0);
        check_val("t6_pcwen", 32'(pc_wen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
